// File: rtl/branch_target_buffer_pkg.sv
// Shared constants for the branch target buffer.
// Contents:
//   BTB_WORD_SIZE  - default PC / instruction width
//   BTB_INDEX_BITS - default table index width (2^BTB_INDEX_BITS entries)
//   cnt_t          - 2-bit direction counter type
//   CNT_*          - counter encodings; bit 1 set means "predict taken"
package branch_target_buffer_pkg;

    localparam int unsigned BTB_WORD_SIZE  = 16;
    localparam int unsigned BTB_INDEX_BITS = 8;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'b00;
    localparam cnt_t CNT_WNT = 2'b01;
    localparam cnt_t CNT_WT  = 2'b10;
    localparam cnt_t CNT_ST  = 2'b11;

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
// Ports:
//   cur                in  2 : current counter value
//   taken              in  1 : resolved direction (increment when set, else decrement)
//   force_strong_taken in  1 : unconditional jump; forces strong-taken
//   next               out 2 : counter value to store
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    input  logic       force_strong_taken,
    output logic [1:0] next
);

    always_comb begin
        next = cur;
        if (force_strong_taken) begin
            next = CNT_ST;
        end else if (taken) begin
            if (cur != CNT_ST) begin
                next = cur + 2'd1;
            end
        end else begin
            if (cur != CNT_SNT) begin
                next = cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer with a 2-bit direction counter per entry.
// Lookup is combinational from the fetch PC; training comes from EX on the clock edge.
// Ports:
//   clk                    in  1         : clock, rising edge
//   reset_n                in  1         : synchronous active-low reset, clears the table
//   pc_IF                  in  WORD_SIZE : fetch PC to look up
//   branch_predicted_pc_IF out WORD_SIZE : stored target on a taken-predicted hit, else pc_IF+1
//   tag_match_IF           out 1         : entry valid and tag equal
//   update_en              in  1         : resolved branch/jump in EX this cycle
//   update_is_jump         in  1         : resolved instruction is an unconditional jump
//   update_pc              in  WORD_SIZE : PC of the resolved instruction
//   update_taken           in  1         : actual direction
//   update_target          in  WORD_SIZE : actual target
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = BTB_WORD_SIZE,
    parameter int unsigned INDEX_BITS = BTB_INDEX_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc_IF,
    output logic [WORD_SIZE-1:0] branch_predicted_pc_IF,
    output logic                 tag_match_IF,
    input  logic                 update_en,
    input  logic                 update_is_jump,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic                 update_taken,
    input  logic [WORD_SIZE-1:0] update_target
);

    localparam int unsigned TAG_BITS    = WORD_SIZE - INDEX_BITS;
    localparam int unsigned NUM_ENTRIES = 1 << INDEX_BITS;

    // Table storage
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [TAG_BITS-1:0]    r_tag    [NUM_ENTRIES];
    logic [WORD_SIZE-1:0]   r_target [NUM_ENTRIES];
    cnt_t                   r_cnt    [NUM_ENTRIES];

    // Lookup side
    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;
    logic                  w_lk_hit;

    assign w_lk_idx = pc_IF[INDEX_BITS-1:0];
    assign w_lk_tag = pc_IF[WORD_SIZE-1:INDEX_BITS];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign tag_match_IF           = w_lk_hit;
    // Natural wrap of the adder gives FFFF -> 0000.
    assign branch_predicted_pc_IF = (w_lk_hit && r_cnt[w_lk_idx][1]) ? r_target[w_lk_idx]
                                                                     : pc_IF + WORD_SIZE'(1);

    // Update side
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [TAG_BITS-1:0]   w_up_tag;
    logic                  w_up_hit;
    logic                  w_up_redirect;
    cnt_t                  w_cnt_next;

    assign w_up_idx      = update_pc[INDEX_BITS-1:0];
    assign w_up_tag      = update_pc[WORD_SIZE-1:INDEX_BITS];
    assign w_up_hit      = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_redirect = update_taken || update_is_jump;

    sat_counter2 u_sat_counter2 (
        .cur                (r_cnt[w_up_idx]),
        .taken              (update_taken),
        .force_strong_taken (update_is_jump),
        .next               (w_cnt_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_WNT;
            end
        end else if (update_en) begin
            if (w_up_hit) begin
                r_cnt[w_up_idx] <= w_cnt_next;
                if (w_up_redirect) begin
                    r_target[w_up_idx] <= update_target;
                end
            end else if (w_up_redirect) begin
                // Miss: overwrite whatever lives at this index.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= update_target;
                r_cnt[w_up_idx]    <= update_is_jump ? CNT_ST : CNT_WT;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc_IF;
    logic [15:0] branch_predicted_pc_IF;
    logic        tag_match_IF;
    logic        update_en;
    logic        update_is_jump;
    logic [15:0] update_pc;
    logic        update_taken;
    logic [15:0] update_target;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(
        .WORD_SIZE  (16),
        .INDEX_BITS (8)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .pc_IF                  (pc_IF),
        .branch_predicted_pc_IF (branch_predicted_pc_IF),
        .tag_match_IF           (tag_match_IF),
        .update_en              (update_en),
        .update_is_jump         (update_is_jump),
        .update_pc              (update_pc),
        .update_taken           (update_taken),
        .update_target          (update_target)
    );

    // Reference model: per-index owner PC upper bits, target and an integer confidence 0..3.
    bit          m_valid [256];
    int          m_owner [256];
    int          m_tgt   [256];
    int          m_conf  [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_owner[i] = 0;
            m_tgt[i]   = 0;
            m_conf[i]  = 1;
        end
    endfunction

    function automatic bit model_hit(input int pc);
        return m_valid[pc % 256] && (m_owner[pc % 256] == pc / 256);
    endfunction

    function automatic int model_pred(input int pc);
        if (model_hit(pc) && m_conf[pc % 256] >= 2) return m_tgt[pc % 256];
        return (pc + 1) % 65536;
    endfunction

    function automatic void model_update(input int pc, input bit jump, input bit taken,
                                         input int tgt);
        int idx = pc % 256;
        if (model_hit(pc)) begin
            if (jump) m_conf[idx] = 3;
            else if (taken) m_conf[idx] = (m_conf[idx] == 3) ? 3 : m_conf[idx] + 1;
            else m_conf[idx] = (m_conf[idx] == 0) ? 0 : m_conf[idx] - 1;
            if (taken || jump) m_tgt[idx] = tgt;
        end else if (taken || jump) begin
            m_valid[idx] = 1'b1;
            m_owner[idx] = pc / 256;
            m_tgt[idx]   = tgt;
            m_conf[idx]  = jump ? 3 : 2;
        end
    endfunction

    // One cycle: drive, check lookup against model (and optional constants), clock, advance model.
    task automatic step(input logic [15:0] pc, input bit ue, input bit uj, input logic [15:0] upc,
                        input bit ut, input logic [15:0] utgt, input bit rst_n, input bit chk,
                        input bit use_exp, input bit exp_hit, input logic [15:0] exp_pred);
        pc_IF          = pc;
        update_en      = ue;
        update_is_jump = uj;
        update_pc      = upc;
        update_taken   = ut;
        update_target  = utgt;
        reset_n        = rst_n;
        @(negedge clk);
        if (chk) begin
            check("hit", 32'(tag_match_IF), 32'(model_hit(int'(pc))));
            check("pred", 32'(branch_predicted_pc_IF), 32'(model_pred(int'(pc))));
            if (use_exp) begin
                check("hit_const", 32'(tag_match_IF), 32'(exp_hit));
                check("pred_const", 32'(branch_predicted_pc_IF), 32'(exp_pred));
            end
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (ue) model_update(int'(upc), uj, ut, int'(utgt));
        #1;
    endtask

    task automatic lookup(input logic [15:0] pc, input bit exp_hit, input logic [15:0] exp_pred);
        step(pc, 0, 0, 16'h0, 0, 16'h0, 1, 1, 1, exp_hit, exp_pred);
    endtask

    task automatic upd(input logic [15:0] upc, input bit uj, input bit ut,
                       input logic [15:0] utgt);
        step(16'h0, 1, uj, upc, ut, utgt, 1, 0, 0, 0, 16'h0);
    endtask

    function automatic logic [15:0] rand_pc();
        logic [15:0] p;
        if ($urandom_range(0, 9) == 0) begin
            p = 16'($urandom);
        end else begin
            p = (16'($urandom_range(0, 3)) << 8) | 16'($urandom_range(0, 7));
        end
        return p;
    endfunction

    initial begin
        model_reset();
        pc_IF = '0; update_en = 0; update_is_jump = 0; update_pc = '0;
        update_taken = 0; update_target = '0; reset_n = 0;
        @(posedge clk); #1;
        step(16'h0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 16'h0);
        step(16'h0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 16'h0);

        // Post-reset lookups
        lookup(16'h0010, 0, 16'h0011);
        lookup(16'hFFFF, 0, 16'h0000);

        // Allocate and predict
        upd(16'h0010, 0, 1, 16'h0040);
        lookup(16'h0010, 1, 16'h0040);

        // Saturation and flip
        upd(16'h0010, 0, 0, 16'h0099);
        upd(16'h0010, 0, 0, 16'h0099);
        lookup(16'h0010, 1, 16'h0011);
        upd(16'h0010, 0, 1, 16'h0040);
        upd(16'h0010, 0, 1, 16'h0040);
        lookup(16'h0010, 1, 16'h0040);
        for (int i = 0; i < 5; i++) upd(16'h0010, 0, 1, 16'h0040);
        upd(16'h0010, 0, 0, 16'h0099);
        lookup(16'h0010, 1, 16'h0040);
        upd(16'h0010, 0, 0, 16'h0099);
        lookup(16'h0010, 1, 16'h0011);

        // Jump and alias
        upd(16'h0105, 1, 1, 16'h0200);
        lookup(16'h0105, 1, 16'h0200);
        upd(16'h0205, 0, 1, 16'h0300);
        lookup(16'h0105, 0, 16'h0106);
        lookup(16'h0205, 1, 16'h0300);

        // Same-cycle read/update sees old contents
        step(16'h0020, 1, 0, 16'h0020, 1, 16'h0080, 1, 1, 1, 0, 16'h0021);
        lookup(16'h0020, 1, 16'h0080);

        // Reset beats a simultaneous update
        step(16'h0030, 1, 0, 16'h0030, 1, 16'h0050, 0, 0, 0, 0, 16'h0);
        lookup(16'h0030, 0, 16'h0031);
        lookup(16'h0020, 0, 16'h0021);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] rpc, upc, tgt;
            bit ue, uj, ut, rn;
            rpc = rand_pc();
            upc = ($urandom_range(0, 3) == 0) ? rpc : rand_pc();
            tgt = 16'($urandom);
            ue  = $urandom_range(0, 1) == 1;
            uj  = $urandom_range(0, 4) == 0;
            ut  = uj || ($urandom_range(0, 1) == 1);
            rn  = $urandom_range(0, 199) != 0;
            step(rpc, ue, uj, upc, ut, tgt, rn, 1, 0, 0, 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
